// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator datapath and its trigger generator.
// ACC_DEPTH is the common default record-length exponent for acc_mem_accumulator and acc_trig_gen.
package acc_pkg;

  localparam int ACC_DEPTH = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_EXT  = 2'd2,
    WAIT_DUMP = 2'd3
  } acc_trig_state_t;

  // Shortest legal pulse spacing: one full record plus a few cycles of accumulator turnaround.
  function automatic int min_pri(input int depth);
    return (1 << depth) + 4;
  endfunction

endpackage

// File: rtl/acc_pri_timer.sv
// Period timer for acc_trig_gen: zeroed on clr, counts while run is high, saturates at full scale.
// last marks the final cycle of a lim-long window; elapsed means a trig next cycle is at least lim after the previous one.
module acc_pri_timer #(
  parameter int PRI_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [PRI_W-1:0] lim,
  output logic             last,
  output logic             elapsed
);

  logic [PRI_W-1:0] cnt;
  logic [PRI_W-1:0] lim_m1;

  assign lim_m1 = lim - PRI_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && (cnt != '1)) begin
      cnt <= cnt + PRI_W'(1);
    end
  end

  assign last    = (cnt == lim_m1);
  assign elapsed = (cnt >= lim_m1);

endmodule

// File: rtl/acc_trig_gen.sv
// Integration trigger generator feeding acc_mem_accumulator: num_int pulses pri apart, timer or ext_trig paced.
// trig follows a sampled start by one cycle and an ext_trig rise by two; a new integration waits for dump_done.
module acc_trig_gen
  import acc_pkg::*;
#(
  parameter int DEPTH  = ACC_DEPTH,
  parameter int PRI_W  = 32,
  parameter int NINT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              ext_mode,
  input  logic              ext_trig,
  input  logic [PRI_W-1:0]  pri,
  input  logic [NINT_W-1:0] num_int,
  input  logic              dump_done,
  output logic              trig,
  output logic              trig_int,
  output logic              int_done,
  output logic [NINT_W-1:0] pulse_cnt,
  output logic              busy,
  output logic              overrun
);

  localparam logic [PRI_W-1:0] MIN_PRI = PRI_W'(min_pri(DEPTH));

  acc_trig_state_t state, state_n;

  logic [PRI_W-1:0]  pri_l;
  logic [NINT_W-1:0] nint_l;
  logic              mode_l;
  logic              ext_s, ext_q;

  logic              start, fire, fire_first, ovr_set;
  logic              rise, last_pulse;
  logic              tmr_last, tmr_elapsed;
  logic [PRI_W-1:0]  tmr_lim;

  assign rise       = ext_s & ~ext_q;
  assign last_pulse = (pulse_cnt == nint_l);
  // External pacing only guarantees MIN_PRI spacing, so its windows are MIN_PRI long.
  assign tmr_lim    = mode_l ? MIN_PRI : pri_l;

  acc_pri_timer #(
    .PRI_W (PRI_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (fire),
    .run     (state == RUN),
    .lim     (tmr_lim),
    .last    (tmr_last),
    .elapsed (tmr_elapsed)
  );

  always_comb begin
    state_n    = state;
    start      = 1'b0;
    fire       = 1'b0;
    fire_first = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      IDLE: begin
        start = enable;
      end
      WAIT_EXT: begin
        if (rise) begin
          fire       = 1'b1;
          fire_first = 1'b1;
          state_n    = RUN;
        end
      end
      RUN: begin
        if (last_pulse) begin
          if (tmr_last) begin
            state_n = WAIT_DUMP;
          end else if (mode_l && rise && !tmr_elapsed) begin
            ovr_set = 1'b1;
          end
        end else if (!mode_l) begin
          fire = tmr_last;
        end else if (rise) begin
          if (tmr_elapsed) begin
            fire = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end
      end
      WAIT_DUMP: begin
        if (dump_done) begin
          if (enable) begin
            start = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Internal mode fires the first pulse straight off the start edge; external waits for a rise.
    if (start) begin
      if (ext_mode) begin
        state_n = WAIT_EXT;
      end else begin
        state_n    = RUN;
        fire       = 1'b1;
        fire_first = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pri_l     <= '0;
      nint_l    <= '0;
      mode_l    <= 1'b0;
      pulse_cnt <= '0;
      trig      <= 1'b0;
      trig_int  <= 1'b0;
      overrun   <= 1'b0;
      ext_s     <= 1'b0;
      ext_q     <= 1'b0;
    end else begin
      state    <= state_n;
      ext_s    <= ext_trig;
      ext_q    <= ext_s;
      trig     <= fire;
      trig_int <= fire_first;

      if (start) begin
        pri_l  <= (pri < MIN_PRI) ? MIN_PRI : pri;
        nint_l <= (num_int == '0) ? NINT_W'(1) : num_int;
        mode_l <= ext_mode;
      end

      if (start) begin
        overrun <= 1'b0;
      end else if (ovr_set) begin
        overrun <= 1'b1;
      end

      if (fire_first) begin
        pulse_cnt <= NINT_W'(1);
      end else if (start) begin
        pulse_cnt <= '0;
      end else if (fire) begin
        pulse_cnt <= pulse_cnt + NINT_W'(1);
      end
    end
  end

  assign int_done = (state == RUN) && last_pulse && tmr_last;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_acc_trig_gen.sv
// Directed bench for acc_trig_gen: a timeline model predicts every output each cycle,
// and hand-computed cycle offsets pin the model for each scenario.
module tb_acc_trig_gen;

  localparam int MINP = 1028;
  localparam int P_IDLE = 0, P_WEXT = 1, P_RUN = 2, P_WDUMP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0, ext_mode = 1'b0, ext_trig = 1'b0, dump_done = 1'b0;
  logic [31:0] pri = 32'd2000;
  logic [15:0] num_int = 16'd4;
  logic        trig, trig_int, int_done, busy, overrun;
  logic [15:0] pulse_cnt;

  acc_trig_gen dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ext_mode  (ext_mode),
    .ext_trig  (ext_trig),
    .pri       (pri),
    .num_int   (num_int),
    .dump_done (dump_done),
    .trig      (trig),
    .trig_int  (trig_int),
    .int_done  (int_done),
    .pulse_cnt (pulse_cnt),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_print = 0;
  bit chk_on = 1'b0;

  // Timeline model: absolute edge numbers, last-trig time and the pending ext request.
  int cyc = 0, ph = P_IDLE, m_cnt = 0, m_P = 0, m_N = 0, t_last = 0, pend = -1;
  bit m_M = 1'b0, m_ovr = 1'b0, ext_prev = 1'b0, e_trig = 1'b0, e_ti = 1'b0, e_done = 1'b0;

  int trig_log[$], ti_log[$], done_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = P_IDLE; m_cnt = 0; m_ovr = 1'b0; ext_prev = 1'b0; pend = -1;
      e_trig = 1'b0; e_ti = 1'b0; e_done = 1'b0;
    end else begin
      bit cand, go;
      int lim;
      cyc++;
      cand = (pend == cyc);
      if (ext_trig && !ext_prev) pend = cyc + 1;
      ext_prev = ext_trig;
      e_trig = 1'b0; e_ti = 1'b0; go = 1'b0;
      lim = m_M ? MINP : m_P;
      case (ph)
        P_IDLE: go = enable;
        P_WEXT: if (cand) begin
          e_trig = 1'b1; e_ti = 1'b1; m_cnt = 1; t_last = cyc; ph = P_RUN;
        end
        P_RUN: begin
          if (m_cnt == m_N) begin
            if (cyc - t_last == lim) ph = P_WDUMP;
            else if (m_M && cand && (cyc - t_last < MINP)) m_ovr = 1'b1;
          end else if (!m_M) begin
            if (cyc - t_last == m_P) begin e_trig = 1'b1; m_cnt++; t_last = cyc; end
          end else if (cand) begin
            if (cyc - t_last >= MINP) begin e_trig = 1'b1; m_cnt++; t_last = cyc; end
            else m_ovr = 1'b1;
          end
        end
        default: if (dump_done) begin
          if (enable) go = 1'b1;
          else ph = P_IDLE;
        end
      endcase
      if (go) begin
        m_P = (pri < 32'(MINP)) ? MINP : int'(pri);
        m_N = (num_int == 16'd0) ? 1 : int'(num_int);
        m_M = ext_mode;
        m_ovr = 1'b0;
        if (!ext_mode) begin
          e_trig = 1'b1; e_ti = 1'b1; m_cnt = 1; t_last = cyc; ph = P_RUN;
        end else begin
          m_cnt = 0; ph = P_WEXT;
        end
      end
      e_done = (ph == P_RUN) && (m_cnt == m_N) && (cyc - t_last == (m_M ? MINP : m_P) - 1);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [20:0] got, exp;
      got = {trig, trig_int, int_done, busy, overrun, pulse_cnt};
      exp = {e_trig, e_ti, e_done, (ph != P_IDLE), m_ovr, 16'(m_cnt)};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL cycle %0d outputs {trig,trig_int,int_done,busy,overrun,pulse_cnt}: got %b, expected %b",
                   cyc, got, exp);
        end
      end
      if (trig) trig_log.push_back(cyc);
      if (trig_int) ti_log.push_back(cyc);
      if (int_done) done_log.push_back(cyc);
    end
  end

  task automatic wait_sig(input int which, input int budget, input string name);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      hit = (which == 0) ? trig : int_done;
      n++;
    end
    if (!hit) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no event within %0d cycles, event required", name, budget);
    end
  endtask

  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic wait_cyc(input int at);
    while (cyc < at) sync();
  endtask

  task automatic dump_pulse();
    dump_done = 1'b1;
    sync();
    dump_done = 1'b0;
  endtask

  task automatic ext_pulse_at(input int at, output int r);
    wait_cyc(at);
    ext_trig = 1'b1;
    r = cyc;
    repeat (3) @(posedge clk);
    #2 ext_trig = 1'b0;
  endtask

  task automatic clear_logs();
    trig_log.delete(); ti_log.delete(); done_log.delete();
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, m, r0, rx, r1, r2, nb;
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset pulse_cnt", pulse_cnt, 0);
    check("reset trig", trig, 0);
    check("reset overrun", overrun, 0);

    // Internal run, pri=2000, four pulses; inputs changed mid-run must not matter.
    clear_logs();
    enable = 1'b1; e = cyc + 1;
    repeat (100) sync();
    pri = 32'd1500; num_int = 16'd9; ext_mode = 1'b1;
    wait_sig(1, 9000, "t1 int_done");
    sync();
    check("t1 trig count", trig_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t1 trig offset", trig_log[i] - e, i * 2000);
    check("t1 trig_int count", ti_log.size(), 1);
    check("t1 trig_int offset", ti_log[0] - e, 0);
    check("t1 int_done offset", done_log[0] - e, 7999);
    check("t1 busy in wait_dump", busy, 1);
    enable = 1'b0;
    dump_pulse();
    @(negedge clk);
    check("t1 idle after dump", busy, 0);

    // Clamp: pri=10 -> 1028, num_int=0 -> 1, then the dump handshake.
    sync();
    clear_logs();
    pri = 32'd10; num_int = 16'd0; ext_mode = 1'b0; enable = 1'b1; e = cyc + 1;
    wait_sig(1, 1500, "t2 int_done");
    sync();
    check("t2 trig count", trig_log.size(), 1);
    check("t2 trig at start", trig_log[0] - e, 0);
    check("t2 trig_int coincides", ti_log[0] - e, 0);
    check("t2 int_done offset", done_log[0] - e, 1027);
    pri = 32'd1500; num_int = 16'd2;
    repeat (500) sync();
    check("t2 no trig while waiting dump", trig_log.size(), 1);
    check("t2 busy while waiting dump", busy, 1);
    check("t2 pulse_cnt held", pulse_cnt, 1);
    dump_done = 1'b1; m = cyc + 1;
    sync();
    dump_done = 1'b0;
    @(negedge clk);
    check("t2 trig after dump", trig, 1);
    check("t2 trig_int after dump", trig_int, 1);
    check("t2 pulse_cnt after dump", pulse_cnt, 1);
    repeat (100) sync();
    dump_pulse();
    wait_sig(1, 3200, "t2 second int_done");
    sync();
    check("t2 trig count total", trig_log.size(), 3);
    check("t2 relaunch offset", trig_log[1] - m, 0);
    check("t2 second trig offset", trig_log[2] - m, 1500);
    check("t2 second int_done offset", done_log[1] - m, 2999);
    enable = 1'b0;
    dump_pulse();

    // External pacing: three pulses, one early edge in between.
    sync();
    clear_logs();
    ext_mode = 1'b1; num_int = 16'd3; pri = 32'd5000; enable = 1'b1;
    repeat (20) sync();
    check("t3 busy waiting ext", busy, 1);
    check("t3 no trig before edge", trig_log.size(), 0);
    enable = 1'b0;
    ext_pulse_at(cyc + 1, r0);
    wait_cyc(r0 + 10);
    check("t3 overrun before early edge", overrun, 0);
    ext_pulse_at(r0 + 500, rx);
    wait_cyc(rx + 10);
    check("t3 early edge ignored", trig_log.size(), 1);
    check("t3 overrun set", overrun, 1);
    ext_pulse_at(r0 + 3000, r1);
    ext_pulse_at(r0 + 6000, r2);
    wait_sig(1, 1500, "t3 int_done");
    sync();
    check("t3 trig count", trig_log.size(), 3);
    check("t3 trig0 latency", trig_log[0] - r0, 2);
    check("t3 trig1 latency", trig_log[1] - r1, 2);
    check("t3 trig2 latency", trig_log[2] - r2, 2);
    check("t3 trig_int count", ti_log.size(), 1);
    check("t3 trig_int on first", ti_log[0] - r0, 2);
    check("t3 int_done after last", done_log[0] - trig_log[2], 1027);
    check("t3 overrun sticky", overrun, 1);
    dump_pulse();

    // Enable dropped after the second of four pulses.
    sync();
    clear_logs();
    ext_mode = 1'b0; pri = 32'd1028; num_int = 16'd4; enable = 1'b1; e = cyc + 1;
    wait_sig(0, 10, "t4 first trig");
    wait_sig(0, 1100, "t4 second trig");
    sync();
    enable = 1'b0;
    wait_sig(1, 4000, "t4 int_done");
    sync();
    check("t4 trig count", trig_log.size(), 4);
    check("t4 last trig offset", trig_log[3] - e, 3084);
    check("t4 int_done offset", done_log[0] - e, 4111);
    check("t4 busy before dump", busy, 1);
    dump_pulse();
    @(negedge clk);
    check("t4 idle after dump", busy, 0);

    // Asynchronous reset in the middle of a trig cycle.
    sync();
    clear_logs();
    pri = 32'd1200; num_int = 16'd5; enable = 1'b1;
    wait_sig(0, 10, "t5 first trig");
    check("t5 pulse_cnt before reset", pulse_cnt, 1);
    check("t5 trig_int before reset", trig_int, 1);
    #2 rst = 1'b1;
    #1;
    check("t5 trig cleared", trig, 0);
    check("t5 trig_int cleared", trig_int, 0);
    check("t5 int_done cleared", int_done, 0);
    check("t5 busy cleared", busy, 0);
    check("t5 pulse_cnt cleared", pulse_cnt, 0);
    enable = 1'b0;
    repeat (3) sync();
    rst = 1'b0;
    nb = trig_log.size();
    repeat (2000) sync();
    check("t5 no trig after reset", trig_log.size(), nb);
    enable = 1'b1;
    wait_sig(0, 10, "t5 trig after re-enable");
    check("t5 trig_int after re-enable", trig_int, 1);
    sync();
    enable = 1'b0;
    repeat (5) sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_trig_gen.md
Name: acc_trig_gen

Overview:
- Pulse/integration trigger generator sitting directly upstream of acc_mem_accumulator; drives its trig and trig_int inputs.
- Issues num_int triggers per integration, spaced pri clocks apart, from an internal timer or from a synchronous external sync input.
- Marks the first pulse of each integration with trig_int.
- After the last pulse, holds off the next integration until the downstream readout reports the accumulator memory drained (dump_done).

Parameters:
- DEPTH, 10, log2 of accumulator record length; MIN_PRI = 2**DEPTH + 4 clocks.
- PRI_W, 32, width of pri input and period timer.
- NINT_W, 16, width of num_int and pulse_cnt.

Ports:
- clk  in  1  system clock (215.04 MHz)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; request integrations
- ext_mode  in  1  0 = internal timer, 1 = ext_trig paced; sampled at integration start
- ext_trig  in  1  synchronous external sync; rising edge = pulse request
- pri  in  PRI_W  pulse period in clocks; sampled at integration start
- num_int  in  NINT_W  pulses per integration; sampled at integration start
- dump_done  in  1  one-cycle pulse from readout: accumulator drained
- trig  out  1  one-cycle pulse per transmitted pulse
- trig_int  out  1  one-cycle pulse, coincident with the first trig of an integration only
- int_done  out  1  one-cycle pulse at end of the last pulse window
- pulse_cnt  out  NINT_W  triggers issued in the current integration
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky; ext edge arrived too early; cleared at integration start

Behaviour:
- Reset (async): state IDLE; trig, trig_int, int_done, busy, overrun = 0; pulse_cnt = 0; timers = 0.
- Integration start latch: pri_l = max(pri, MIN_PRI); nint_l = max(num_int, 1); mode_l = ext_mode; overrun cleared.
- States: IDLE, RUN, WAIT_EXT, WAIT_DUMP.
- IDLE: enable sampled 1 on edge N → latch, then:
  - internal mode: trig = trig_int = 1 in cycle N+1, pulse_cnt = 1, state RUN.
  - external mode: state WAIT_EXT.
- RUN (internal):
  - Period timer zeroed in each trig cycle.
  - Subsequent trig when timer reaches pri_l, so trigs are exactly pri_l cycles apart.
  - pulse_cnt increments in the trig cycle.
- WAIT_EXT / external RUN:
  - Rising edge detected against a 1-cycle registered copy of ext_trig; trig issued 1 cycle after the edge is sampled.
  - First trig of the integration carries trig_int.
  - An edge arriving fewer than MIN_PRI cycles after the previous trig is ignored and sets overrun.
- Completion:
  - After trig number nint_l, the timer runs to pri_l−1 (internal) or MIN_PRI−1 (external).
  - int_done = 1 for that one cycle; next state WAIT_DUMP.
- WAIT_DUMP:
  - dump_done accepted only in this state; dump_done elsewhere is ignored.
  - On dump_done at edge M: if enable = 1, relatch inputs and start a new integration as from IDLE (internal trig + trig_int at M+1); else go to IDLE.
- enable dropped mid-integration: current integration completes normally (all nint_l pulses, int_done), then WAIT_DUMP, then IDLE.
- Input changes: pri/num_int/ext_mode changes mid-integration have no effect until the next latch.
- Boundary cases:
  - nint_l = 1: trig and trig_int coincide; int_done follows the single window.
  - pulse_cnt saturates at nint_l, holds through WAIT_DUMP, and is zeroed at the next start.
  - trig and int_done are never asserted in the same cycle.
- Reset mid-operation: immediate return to IDLE; no partial pulses; outputs 0.

Decomposition:
- Package acc_pkg:
  - state enum acc_trig_state_t {IDLE, RUN, WAIT_EXT, WAIT_DUMP}.
  - MIN_PRI as a function of DEPTH.
  - Shared DEPTH default, also used by acc_mem_accumulator.
- One natural sub-module: acc_pri_timer, the loadable up-counter with terminal-count compare (pri_l and pri_l−1 strobes).
- Edge detector and FSM stay in the top level.

Test Plan:
- Internal run: reset, pri=2000, num_int=4, enable high at edge 0 → trig at cycles 1, 2001, 4001, 6001; trig_int only at 1; int_done at 8000; busy high 1..8000+.
- Clamp/zero: pri=10, num_int=0 → single trig+trig_int at cycle 1; int_done at cycle 1028 (MIN_PRI=1028).
- Dump handshake: after int_done, hold dump_done low 500 cycles → no trig; dump_done pulse at M with enable=1 → trig+trig_int at M+1, pulse_cnt=1; dump_done pulsed during RUN → ignored.
- External mode: ext_mode=1, num_int=3, ext edges 3000 apart → trig 2 cycles after each ext_trig rise, trig_int on first; edge 500 after a trig → no trig, overrun=1 until next start.
- Enable drop: deassert enable after the 2nd of 4 pulses → pulses 3 and 4 still issued, int_done, then IDLE after dump_done, busy=0.
- Async reset mid-RUN: assert rst between edges → trig/trig_int/int_done/busy/pulse_cnt = 0 immediately; no further trigs until enable re-sampled.
